// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory responder.
//   dmem_state_t : responder FSM states (IDLE accepts requests, WAIT models
//                  the access latency)
//   XFER_*       : legal transfer sizes in bytes
//   size_legal() : true when a transfer size is one of XFER_*
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } dmem_state_t;

   localparam logic [3:0] XFER_B = 4'd1;
   localparam logic [3:0] XFER_H = 4'd2;
   localparam logic [3:0] XFER_W = 4'd4;
   localparam logic [3:0] XFER_D = 4'd8;

   function automatic logic size_legal(input logic [3:0] size);
      return (size == XFER_B) || (size == XFER_H) ||
             (size == XFER_W) || (size == XFER_D);
   endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lane_ctrl
// Combinational byte-lane decoder for one 8-byte memory row.
//   i_addr_lo   : byte offset within the row (address[2:0])
//   i_xfer_size : transfer size in bytes
//   o_byte_en   : one bit per byte lane touched by the access
//   o_misalign  : address is not a multiple of the transfer size
// An illegal size yields an empty mask and no misalign flag; the caller
// rejects it on its own.
// -----------------------------------------------------------------------------
module dmem_lane_ctrl
   import dmem_pkg::*;
(
   input  logic [2:0] i_addr_lo,
   input  logic [3:0] i_xfer_size,
   output logic [7:0] o_byte_en,
   output logic       o_misalign
);

   logic [7:0] w_base_mask;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      w_base_mask = 8'h00;
      o_misalign  = 1'b0;
      case (i_xfer_size)
         XFER_B: w_base_mask = 8'h01;
         XFER_H: begin
            w_base_mask = 8'h03;
            o_misalign  = i_addr_lo[0];
         end
         XFER_W: begin
            w_base_mask = 8'h0F;
            o_misalign  = |i_addr_lo[1:0];
         end
         XFER_D: begin
            w_base_mask = 8'hFF;
            o_misalign  = |i_addr_lo;
         end
         default: ;
      endcase
   end

   // An aligned access never spills past lane 7, so the shift cannot lose bits.
   assign o_byte_en = w_base_mask << i_addr_lo;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Byte-addressed data memory serving one load/store at a time with a fixed
// access latency, size/alignment checking and zero-extended loads.
//   clk, reset    : single clock, synchronous active-high reset
//   address       : byte address, wrapped to log2(DEPTH_BYTES) bits
//   read_enable   : load request
//   write_enable  : store request
//   xfer_size     : bytes to move (1, 2, 4, 8)
//   write_data    : store data, low xfer_size bytes used
//   ready         : idle, a request is sampled on this edge
//   done          : one-cycle completion pulse
//   read_data     : last load result, zero-extended
//   err           : one-cycle pulse for a rejected request
// Storage is organised as 8-byte rows written through byte enables.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] address,
   input  logic        read_enable,
   input  logic        write_enable,
   input  logic [3:0]  xfer_size,
   input  logic [63:0] write_data,
   output logic        ready,
   output logic        done,
   output logic [63:0] read_data,
   output logic        err
);

   localparam int AW   = $clog2(DEPTH_BYTES);
   localparam int RW   = (AW > 3) ? (AW - 3) : 1;
   localparam int ROWS = DEPTH_BYTES / 8;
   localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmem_state_t   r_state;
   dmem_state_t   w_state_next;
   logic [CW-1:0] r_count;

   logic [RW-1:0] r_row;
   logic [2:0]    r_lane;
   logic [7:0]    r_byte_en;
   logic          r_is_write;
   logic [63:0]   r_wdata;

   logic          r_done;
   logic          r_err;
   logic [63:0]   r_rdata;

   logic [63:0]   r_mem [ROWS];

   logic [RW-1:0] w_row;
   logic [7:0]    w_byte_en;
   logic          w_misalign;
   logic          w_req;
   logic          w_reject;
   logic          w_accept;
   logic          w_commit;
   logic [63:0]   w_rd_shifted;
   logic [7:0]    w_rd_be;
   logic [63:0]   w_rd_data;
   logic          w_unused_addr;

   // Address bits above the storage size simply alias.
   assign w_unused_addr = ^address[63:AW];

   if (AW > 3) begin : g_row
      assign w_row = address[AW-1:3];
   end else begin : g_single_row
      assign w_row = '0;
   end

   dmem_lane_ctrl u_lane_ctrl (
      .i_addr_lo   (address[2:0]),
      .i_xfer_size (xfer_size),
      .o_byte_en   (w_byte_en),
      .o_misalign  (w_misalign)
   );

   assign w_req    = read_enable | write_enable;
   assign w_reject = w_req & ((read_enable & write_enable) |
                              ~size_legal(xfer_size) | w_misalign);
   assign w_accept = w_req & ~w_reject;
   assign w_commit = (r_state == WAIT) && (r_count == '0);

   // ---------------------------------------------------------------- FSM
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = WAIT;
         WAIT:    if (r_count == '0) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         r_done  <= w_commit;
         r_err   <= (r_state == IDLE) && w_reject;
         if ((r_state == IDLE) && w_accept) begin
            r_count <= CW'(LATENCY - 1);
         end else if ((r_state == WAIT) && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
         end
         if (w_commit && !r_is_write) begin
            r_rdata <= w_rd_data;
         end
      end
   end

   // Request latch: only meaningful while WAIT, so it needs no reset.
   // Store data is pre-shifted into its byte lanes at acceptance.
   always_ff @(posedge clk) begin
      if ((r_state == IDLE) && w_accept) begin
         r_row      <= w_row;
         r_lane     <= address[2:0];
         r_byte_en  <= w_byte_en;
         r_is_write <= write_enable;
         r_wdata    <= write_data << {address[2:0], 3'b000};
      end
   end

   // NOTE: the storage array is deliberately not reset; contents survive a
   // reset and power up to zero from the device's RAM configuration. Gating
   // on reset drops a store whose commit edge coincides with reset.
   always_ff @(posedge clk) begin
      if (w_commit && r_is_write && !reset) begin
         for (int b = 0; b < 8; b++) begin
            if (r_byte_en[b]) begin
               r_mem[r_row][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

   // Load path: bring the addressed lanes down to bit 0 and keep only the
   // transferred bytes, which zero-extends the result.
   assign w_rd_shifted = r_mem[r_row] >> {r_lane, 3'b000};
   assign w_rd_be      = r_byte_en >> r_lane;

   always_comb begin
      w_rd_data = '0;
      for (int b = 0; b < 8; b++) begin
         if (w_rd_be[b]) begin
            w_rd_data[8*b +: 8] = w_rd_shifted[8*b +: 8];
         end
      end
   end

   assign ready     = (r_state == IDLE);
   assign done      = r_done;
   assign err       = r_err;
   assign read_data = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. Two instances share clock and
// reset: LATENCY=2 for the functional sequence and LATENCY=1 for the
// back-to-back throughput sequence. A byte-array model predicts every
// outcome; predictions go into a scoreboard queue when a request is driven
// and are popped when the responder signals done or err.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int AW    = $clog2(DEPTH);

   typedef enum int {K_LOAD, K_STORE, K_ERR} kind_e;
   typedef struct {
      kind_e       kind;
      logic [63:0] data;
      int          n;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;

   logic [63:0] a_address, a_wdata, a_rdata;
   logic        a_re, a_we, a_ready, a_done, a_err;
   logic [3:0]  a_size;

   logic [63:0] b_address, b_wdata, b_rdata;
   logic        b_re, b_we, b_ready, b_done, b_err;
   logic [3:0]  b_size;

   int          checks   = 0;
   int          failures = 0;

   logic [7:0]  mdl [2][DEPTH];
   logic [63:0] rd_m [2];
   exp_t        sb[$];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) u_dut_l2 (
      .clk          (clk),
      .reset        (reset),
      .address      (a_address),
      .read_enable  (a_re),
      .write_enable (a_we),
      .xfer_size    (a_size),
      .write_data   (a_wdata),
      .ready        (a_ready),
      .done         (a_done),
      .read_data    (a_rdata),
      .err          (a_err)
   );

   dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u_dut_l1 (
      .clk          (clk),
      .reset        (reset),
      .address      (b_address),
      .read_enable  (b_re),
      .write_enable (b_we),
      .xfer_size    (b_size),
      .write_data   (b_wdata),
      .ready        (b_ready),
      .done         (b_done),
      .read_data    (b_rdata),
      .err          (b_err)
   );

   function automatic logic get_ready(input bit sel);
      return sel ? b_ready : a_ready;
   endfunction
   function automatic logic get_done(input bit sel);
      return sel ? b_done : a_done;
   endfunction
   function automatic logic get_err(input bit sel);
      return sel ? b_err : a_err;
   endfunction
   function automatic logic [63:0] get_rdata(input bit sel);
      return sel ? b_rdata : a_rdata;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic re, input logic we,
                        input logic [3:0] size, input logic [63:0] addr,
                        input logic [63:0] wdata);
      if (sel) begin
         b_re = re; b_we = we; b_size = size; b_address = addr; b_wdata = wdata;
      end else begin
         a_re = re; a_we = we; a_size = size; a_address = addr; a_wdata = wdata;
      end
   endtask

   // Issue one request at a negedge, predict its outcome, then watch the
   // responder (bounded) and compare event kind, timing, ready and read_data.
   // With noise set, conflicting stores to address 48 are driven during WAIT.
   task automatic access(input bit sel, input string tag, input logic re, input logic we,
                         input logic [3:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, input bit noise);
      exp_t        e;
      int          lat, base, ev_n, obs_cls, exp_cls;
      bit          legal, ready_ok, extra;
      logic [63:0] d, rd_at_ev;

      lat  = sel ? 1 : 2;
      base = int'(addr[AW-1:0]);
      legal = (re != we);
      if (!(size inside {4'd1, 4'd2, 4'd4, 4'd8})) legal = 1'b0;
      else if ((addr % 64'(size)) != 64'd0) legal = 1'b0;

      if (!legal) begin
         e.kind = K_ERR;
         e.data = rd_m[sel];
      end else if (we) begin
         for (int i = 0; i < int'(size); i++) mdl[sel][base+i] = wdata[8*i +: 8];
         e.kind = K_STORE;
         e.data = rd_m[sel];
      end else begin
         d = '0;
         for (int i = 0; i < int'(size); i++) d[8*i +: 8] = mdl[sel][base+i];
         rd_m[sel] = d;
         e.kind = K_LOAD;
         e.data = d;
      end
      e.n = legal ? lat + 1 : 1;
      sb.push_back(e);

      check({tag, ".ready_in"}, 64'(get_ready(sel)), 64'd1);
      drive(sel, re, we, size, addr, wdata);
      @(posedge clk);
      #1;
      if (noise) drive(sel, 1'b0, 1'b1, 4'd8, 64'd48, {$urandom, $urandom});
      else       drive(sel, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0);

      ready_ok = 1'b1; extra = 1'b0; ev_n = 0; obs_cls = 0; rd_at_ev = '0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (get_ready(sel) !== ((!legal || n > lat) ? 1'b1 : 1'b0)) ready_ok = 1'b0;
         if (ev_n == 0 && (get_done(sel) || get_err(sel))) begin
            ev_n     = n;
            obs_cls  = get_err(sel) ? 2 : 1;
            rd_at_ev = get_rdata(sel);
            if (get_done(sel) && get_err(sel)) extra = 1'b1;
         end else if (ev_n != 0 && (get_done(sel) || get_err(sel))) begin
            extra = 1'b1;
         end
         if (noise && n < lat) drive(sel, n[0], ~n[0], 4'd8, 64'd48, {$urandom, $urandom});
         else                  drive(sel, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
         if (ev_n != 0 && (legal || n >= 4)) break;
      end

      e = sb.pop_front();
      exp_cls = (e.kind == K_ERR) ? 2 : 1;
      check({tag, ".event"},  64'(obs_cls), 64'(exp_cls));
      check({tag, ".cycles"}, 64'(ev_n), 64'(e.n));
      check({tag, ".rdata"},  rd_at_ev, e.data);
      check({tag, ".ready"},  64'(ready_ok), 64'd1);
      if (!legal) check({tag, ".no_done"}, 64'(extra), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic       done_seen;
      logic [3:0] sz;
      logic [63:0] ad, wd;

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < DEPTH; i++) mdl[s][i] = 8'h00;
         rd_m[s] = '0;
      end
      drive(1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.a_ready", 64'(a_ready), 64'd1);
      check("rst.a_done",  64'(a_done),  64'd0);
      check("rst.a_err",   64'(a_err),   64'd0);
      check("rst.a_rdata", a_rdata,      64'd0);
      check("rst.b_ready", 64'(b_ready), 64'd1);
      check("rst.b_rdata", b_rdata,      64'd0);
      reset = 1'b0;

      // Store/load round trip and sub-word accesses.
      access(1'b0, "st16",   1'b0, 1'b1, 4'd8, 64'd16, 64'h1122334455667788, 1'b0);
      access(1'b0, "ld16",   1'b1, 1'b0, 4'd8, 64'd16, 64'd0, 1'b0);
      access(1'b0, "stb19",  1'b0, 1'b1, 4'd1, 64'd19, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
      access(1'b0, "ldw16",  1'b1, 1'b0, 4'd4, 64'd16, 64'd0, 1'b0);
      access(1'b0, "ldh22",  1'b1, 1'b0, 4'd2, 64'd22, 64'd0, 1'b0);

      // Rejections leave memory and read_data alone.
      access(1'b0, "rej_mis",  1'b1, 1'b0, 4'd4, 64'd18, 64'd0, 1'b0);
      access(1'b0, "rej_sz3",  1'b0, 1'b1, 4'd3, 64'd16, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
      access(1'b0, "rej_both", 1'b1, 1'b1, 4'd8, 64'd16, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
      access(1'b0, "rej_st2",  1'b0, 1'b1, 4'd2, 64'd17, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
      access(1'b0, "ld16b",    1'b1, 1'b0, 4'd8, 64'd16, 64'd0, 1'b0);

      // Address wrap and requests ignored while busy.
      access(1'b0, "st_wrap", 1'b0, 1'b1, 4'd8, 64'(DEPTH + 8), 64'hCAFE_F00D_0BAD_BEEF, 1'b0);
      access(1'b0, "ld8",     1'b1, 1'b0, 4'd8, 64'd8, 64'd0, 1'b0);
      access(1'b0, "st48",    1'b0, 1'b1, 4'd8, 64'd48, 64'h0102_0304_0506_0708, 1'b0);
      access(1'b0, "st40_bz", 1'b0, 1'b1, 4'd8, 64'd40, 64'hA5A5_5A5A_C3C3_3C3C, 1'b1);
      access(1'b0, "ld48",    1'b1, 1'b0, 4'd8, 64'd48, 64'd0, 1'b0);
      access(1'b0, "ld40",    1'b1, 1'b0, 4'd8, 64'd40, 64'd0, 1'b0);

      // Reset during WAIT discards the pending store.
      access(1'b0, "st0", 1'b0, 1'b1, 4'd8, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 4'd8, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      rd_m[0] = '0;
      rd_m[1] = '0;
      @(negedge clk);
      check("rstw.ready", 64'(a_ready), 64'd1);
      check("rstw.done",  64'(a_done),  64'd0);
      check("rstw.rdata", a_rdata,      64'd0);
      check("rstw.b_rdata", b_rdata,    64'd0);
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (a_done) done_seen = 1'b1;
      end
      check("rstw.no_done", 64'(done_seen), 64'd0);
      access(1'b0, "ld0", 1'b1, 1'b0, 4'd8, 64'd0, 64'd0, 1'b0);

      // LATENCY=1: alternating stores and loads at full rate.
      for (int k = 0; k < 8; k++) begin
         sz = 4'(1 << (k % 4));
         ad = 64'(128 + 8 * k) + ((sz < 4'd8) ? 64'(sz) : 64'd0);
         wd = {$urandom, $urandom};
         access(1'b1, $sformatf("b_st%0d", k), 1'b0, 1'b1, sz, ad, wd, 1'b0);
         access(1'b1, $sformatf("b_ld%0d", k), 1'b1, 1'b0, sz, ad, 64'd0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
